window3x3_linebuf_rgb888: RTL and testbench

Upstream window generator for the 3x3 RGB888 convolution stage. It accepts a raster-order RGB888 pixel stream, one pixel per valid cycle. It holds the two previous image lines in internal line buffers and emits a registered 3x3 pixel window with a one-cycle enable. The outputs connect directly to the convolution stage's nine window inputs and its enable input. Only fully interior windows are produced, with no padding, so output frame size is (IMG_WIDTH-2) x (IMG_HEIGHT-2).

---
 rtl/window3x3_linebuf_rgb888.sv | 112 +++++++++++
 tb/tb_window3x3_linebuf_rgb888.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/window3x3_linebuf_rgb888.sv
`default_nettype none
// ============================================================================
// Module   : window3x3_linebuf_rgb888
// Brief    : Two-line-buffer 3x3 RGB888 window generator (interior windows only)
// Revision : 1.0
// ============================================================================
module window3x3_linebuf_rgb888 #(
    parameter int IMG_WIDTH  = 640,
    parameter int IMG_HEIGHT = 480,
    parameter int COL_W      = 10,
    parameter int ROW_W      = 9
) (
    input  logic        iClk,
    input  logic        iRst_n,
    input  logic        i_valid,
    input  logic        i_sof,
    input  logic [23:0] i_data,
    output logic [23:0] o_p1,
    output logic [23:0] o_p2,
    output logic [23:0] o_p3,
    output logic [23:0] o_p4,
    output logic [23:0] o_p5,
    output logic [23:0] o_p6,
    output logic [23:0] o_p7,
    output logic [23:0] o_p8,
    output logic [23:0] o_p9,
    output logic        o_enable,
    output logic        o_eof
);

    localparam logic [COL_W-1:0] C_LAST_COL = COL_W'(IMG_WIDTH - 1);
    localparam logic [ROW_W-1:0] C_LAST_ROW = ROW_W'(IMG_HEIGHT - 1);
    localparam logic [COL_W-1:0] C_MIN_COL  = COL_W'(2);
    localparam logic [ROW_W-1:0] C_MIN_ROW  = ROW_W'(2);

    logic [23:0]      r_lb0 [IMG_WIDTH];
    logic [23:0]      r_lb1 [IMG_WIDTH];
    logic [23:0]      r_win [9];
    logic [COL_W-1:0] r_col;
    logic [ROW_W-1:0] r_row;
    logic             r_enable;
    logic             r_eof;

    logic [COL_W-1:0] w_col;
    logic [ROW_W-1:0] w_row;
    logic [23:0]      w_top;
    logic [23:0]      w_mid;
    logic             w_hit;
    logic             w_last;

    // A start-of-frame pixel is position (0,0) regardless of the counters.
    assign w_col  = i_sof ? '0 : r_col;
    assign w_row  = i_sof ? '0 : r_row;
    assign w_top  = r_lb1[w_col];
    assign w_mid  = r_lb0[w_col];
    assign w_hit  = (w_row >= C_MIN_ROW) && (w_col >= C_MIN_COL);
    assign w_last = (w_row == C_LAST_ROW) && (w_col == C_LAST_COL);

    // Line-buffer storage needs no reset; rows 0-1 of any frame refill it before use.
    always_ff @(posedge iClk) begin
        if (i_valid) begin
            r_lb1[w_col] <= w_mid;
            r_lb0[w_col] <= i_data;
        end
    end

    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            r_col    <= '0;
            r_row    <= '0;
            r_enable <= 1'b0;
            r_eof    <= 1'b0;
            for (int k = 0; k < 9; k++) begin
                r_win[k] <= '0;
            end
        end else if (i_valid) begin
            if (w_col == C_LAST_COL) begin
                r_col <= '0;
                r_row <= (w_row == C_LAST_ROW) ? '0 : w_row + 1'b1;
            end else begin
                r_col <= w_col + 1'b1;
                r_row <= w_row;
            end
            for (int k = 0; k < 3; k++) begin
                r_win[3*k]   <= r_win[3*k+1];
                r_win[3*k+1] <= r_win[3*k+2];
            end
            r_win[2] <= w_top;
            r_win[5] <= w_mid;
            r_win[8] <= i_data;
            r_enable <= w_hit;
            r_eof    <= w_hit && w_last;
        end else begin
            r_enable <= 1'b0;
            r_eof    <= 1'b0;
        end
    end

    assign o_p1     = r_win[0];
    assign o_p2     = r_win[1];
    assign o_p3     = r_win[2];
    assign o_p4     = r_win[3];
    assign o_p5     = r_win[4];
    assign o_p6     = r_win[5];
    assign o_p7     = r_win[6];
    assign o_p8     = r_win[7];
    assign o_p9     = r_win[8];
    assign o_enable = r_enable;
    assign o_eof    = r_eof;

endmodule
`default_nettype wire

// File: tb/tb_window3x3_linebuf_rgb888.sv
`default_nettype none
// ============================================================================
// Module   : tb_window3x3_linebuf_rgb888
// Brief    : Directed self-checking bench for the 3x3 window generator (5x4 frames)
// Revision : 1.0
// ============================================================================
module tb_window3x3_linebuf_rgb888;

    localparam int W = 5;
    localparam int H = 4;

    logic        iClk;
    logic        iRst_n;
    logic        i_valid;
    logic        i_sof;
    logic [23:0] i_data;
    logic [23:0] o_p1, o_p2, o_p3, o_p4, o_p5, o_p6, o_p7, o_p8, o_p9;
    logic        o_enable;
    logic        o_eof;

    int          checks;
    int          errors;
    int          nwin;
    logic [23:0] snap [9];

    window3x3_linebuf_rgb888 #(
        .IMG_WIDTH (W),
        .IMG_HEIGHT(H),
        .COL_W     (3),
        .ROW_W     (2)
    ) dut (
        .iClk    (iClk),
        .iRst_n  (iRst_n),
        .i_valid (i_valid),
        .i_sof   (i_sof),
        .i_data  (i_data),
        .o_p1    (o_p1),
        .o_p2    (o_p2),
        .o_p3    (o_p3),
        .o_p4    (o_p4),
        .o_p5    (o_p5),
        .o_p6    (o_p6),
        .o_p7    (o_p7),
        .o_p8    (o_p8),
        .o_p9    (o_p9),
        .o_enable(o_enable),
        .o_eof   (o_eof)
    );

    initial iClk = 1'b0;
    always #5 iClk = ~iClk;

    function automatic logic [23:0] pix(input int r, input int c, input logic [7:0] goff);
        logic [7:0] rr;
        logic [7:0] cc;
        rr = 8'(r);
        cc = 8'(c) + goff;
        return {rr, cc, 8'hA5};
    endfunction

    task automatic chk(input string tag, input logic [23:0] obs, input logic [23:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic grab(output logic [23:0] o [9]);
        o[0] = o_p1; o[1] = o_p2; o[2] = o_p3;
        o[3] = o_p4; o[4] = o_p5; o[5] = o_p6;
        o[6] = o_p7; o[7] = o_p8; o[8] = o_p9;
    endtask

    // Accept pixel (r,c) of a frame whose G channel is offset by goff.
    task automatic accept(input int r, input int c, input logic [7:0] goff, input logic sof);
        logic [23:0] obs [9];
        logic        exp_en;
        @(negedge iClk);
        i_valid = 1'b1;
        i_sof   = sof;
        i_data  = pix(r, c, goff);
        @(posedge iClk);
        #1;
        exp_en = (r >= 2) && (c >= 2);
        chk("enable", {23'd0, o_enable}, {23'd0, exp_en});
        chk("eof", {23'd0, o_eof}, {23'd0, exp_en && r == H-1 && c == W-1});
        grab(obs);
        if (exp_en) begin
            nwin++;
            for (int k = 0; k < 9; k++) begin
                chk($sformatf("p%0d@(%0d,%0d)", k+1, r, c), obs[k], pix(r-2+k/3, c-2+k%3, goff));
            end
        end
        for (int k = 0; k < 9; k++) snap[k] = obs[k];
    endtask

    task automatic idle();
        logic [23:0] obs [9];
        @(negedge iClk);
        i_valid = 1'b0;
        i_sof   = 1'b0;
        i_data  = 24'hDEAD00;
        @(posedge iClk);
        #1;
        chk("gap_enable", {23'd0, o_enable}, 24'd0);
        chk("gap_eof", {23'd0, o_eof}, 24'd0);
        grab(obs);
        for (int k = 0; k < 9; k++) chk($sformatf("gap_hold_p%0d", k+1), obs[k], snap[k]);
    endtask

    task automatic frame(input logic [7:0] goff, input int gap);
        nwin = 0;
        for (int r = 0; r < H; r++) begin
            for (int c = 0; c < W; c++) begin
                accept(r, c, goff, (r == 0) && (c == 0));
                if (r == 2 && c == 2) chk("first_p1", o_p1, {8'h00, goff, 8'hA5});
                repeat (gap) idle();
            end
        end
        chk("win_count", 24'(nwin), 24'd6);
    endtask

    task automatic partial(input int n);
        for (int k = 0; k < n; k++) accept(k / W, k % W, 8'h00, k == 0);
    endtask

    initial begin
        checks  = 0;
        errors  = 0;
        nwin    = 0;
        iRst_n  = 1'b0;
        i_valid = 1'b0;
        i_sof   = 1'b0;
        i_data  = '0;
        repeat (2) @(posedge iClk);
        #1;
        chk("rst_enable", {23'd0, o_enable}, 24'd0);
        chk("rst_eof", {23'd0, o_eof}, 24'd0);
        chk("rst_p1", o_p1, 24'd0);
        chk("rst_p9", o_p9, 24'd0);
        @(negedge iClk);
        iRst_n = 1'b1;

        // Continuous frame; last window held afterwards.
        frame(8'h00, 0);
        idle();
        chk("last_p9", o_p9, 24'h0304A5);
        chk("last_p1", o_p1, 24'h0102A5);

        // Same frame with 3-cycle gaps between pixels.
        frame(8'h00, 3);

        // Back-to-back frames, second with shifted G.
        frame(8'h00, 0);
        frame(8'h10, 0);

        // Restart mid-frame at what would be pixel (2,3).
        partial(13);
        frame(8'h20, 0);

        // Asynchronous reset mid-row 2, after a window has been produced.
        partial(13);
        chk("pre_rst_enable", {23'd0, o_enable}, 24'd1);
        @(negedge iClk);
        i_valid = 1'b0;
        #2;
        iRst_n = 1'b0;
        #1;
        chk("async_rst_enable", {23'd0, o_enable}, 24'd0);
        chk("async_rst_p1", o_p1, 24'd0);
        chk("async_rst_p5", o_p5, 24'd0);
        chk("async_rst_p9", o_p9, 24'd0);
        repeat (2) @(posedge iClk);
        @(negedge iClk);
        iRst_n = 1'b1;
        frame(8'h30, 0);

        // Boundary: single-cycle enable at (2,2).
        partial(13);
        idle();
        accept(2, 3, 8'h00, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
